// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  uart_pkg : shared receive-state encoding and default frame geometry
//  Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam int DEF_OVERSAMPLE  = 16;
  localparam int DEF_DATA_BITS   = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int CNT_W           = $clog2(DEF_OVERSAMPLE);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
//  sync_ff  : multi-flop synchronizer for one asynchronous input, resets to 1
//  Revision : 1.0
// ============================================================================
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
  end

  // Reset value 1 keeps an idle-high line from looking like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  uart_rx_ctrl : 16x-oversampled UART receiver with valid/ack byte handoff
//  Revision     : 1.0
// ============================================================================
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int             CW    = $clog2(OVERSAMPLE);
  localparam int             BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0]  MID   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]  LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_rx_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (rx_in),
    .sync_out (rx_s)
  );

  rx_state_e            state_q,     state_d;
  logic [CW-1:0]        cnt_q,       cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q,   bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
  logic                 rx_valid_q,  rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q,   overrun_d;
  logic                 busy_q,      busy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~rx_ack;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (sample_en) begin
          if (cnt_q == MID) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d   = DATA;
              cnt_d     = '0;
              bit_cnt_d = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (sample_en) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // Right shift so the first (LSB) bit ends up at bit 0.
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              state_d = STOP;
            end
          end
        end
      end
      STOP: begin
        if (sample_en) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            if (rx_s) begin
              state_d = IDLE;
              // An ack landing on the completion edge frees the holding register.
              if (!rx_valid_q || rx_ack) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_IDLE;
            end
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
